// File: rtl/gpio_key_pkg.sv
// rtl/gpio_key_pkg.sv - register offsets and edge-select encoding shared by the key input block
package gpio_key_pkg;

  localparam logic [3:0] GPIO_KEY_DATA     = 4'h0;
  localparam logic [3:0] GPIO_KEY_IRQ_EN   = 4'h4;
  localparam logic [3:0] GPIO_KEY_PENDING  = 4'h8;
  localparam logic [3:0] GPIO_KEY_EDGE_SEL = 4'hC;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_sel_e;

endpackage

// File: rtl/gpio_debounce_bit.sv
// rtl/gpio_debounce_bit.sv - synchronizer, polarity fix and debounce counter for one key pin
module gpio_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level
);
  import gpio_key_pkg::*;

  localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] THRESH = CW'(DEBOUNCE_CYCLES);
  localparam logic          INV    = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1] ^ INV;

  // Flops reset to the raw "released" pin value so the chain reads released
  // (s=0) and a key held through reset is re-synchronized from scratch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {SYNC_STAGES{INV}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (s == level) begin
      cnt <= '0;
    end else if (cnt + 1'b1 == THRESH) begin
      level <= s;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gpio_key_input.sv
// rtl/gpio_key_input.sv - debounced key inputs with edge detect, sticky pending bits and a register window
module gpio_key_input #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [3:0]       bus_addr,
  input  logic             bus_write,
  input  logic [31:0]      bus_wdata,
  input  logic             bus_read,
  output logic [31:0]      bus_rdata,
  output logic [WIDTH-1:0] level,
  output logic             irq
);
  import gpio_key_pkg::*;

  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] edge_sel;
  logic [WIDTH-1:0] set_mask;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      rd_val;
  logic [3:0]       reg_off;
  logic             unused_bits;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .pin  (pin_in[i]),
      .level(level[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= '0;
      rise    <= '0;
      fall    <= '0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;
      fall    <= ~level & level_d;
    end
  end

  assign reg_off     = {bus_addr[3:2], 2'b00};
  assign unused_bits = ^{bus_addr[1:0], bus_wdata};

  always_comb begin
    set_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      set_mask[i] = (edge_sel_e'(edge_sel[i]) == EDGE_FALL) ? fall[i] : rise[i];
    end
    clr_mask = (bus_write && reg_off == GPIO_KEY_PENDING) ? bus_wdata[WIDTH-1:0] : '0;
  end

  always_comb begin
    rd_val = '0;
    case (reg_off)
      GPIO_KEY_DATA:     rd_val[WIDTH-1:0] = level;
      GPIO_KEY_IRQ_EN:   rd_val[WIDTH-1:0] = irq_en;
      GPIO_KEY_PENDING:  rd_val[WIDTH-1:0] = pending;
      GPIO_KEY_EDGE_SEL: rd_val[WIDTH-1:0] = edge_sel;
      default:           rd_val = '0;
    endcase
  end

  // Set is OR-ed in after the clear so a same-cycle edge survives a W1C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      irq_en    <= '0;
      edge_sel  <= '0;
      bus_rdata <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (bus_write && reg_off == GPIO_KEY_IRQ_EN) begin
        irq_en <= bus_wdata[WIDTH-1:0];
      end
      if (bus_write && reg_off == GPIO_KEY_EDGE_SEL) begin
        edge_sel <= bus_wdata[WIDTH-1:0];
      end
      if (bus_read) begin
        bus_rdata <= rd_val;
      end
    end
  end

  assign irq = |(pending & irq_en);

endmodule

// File: tb/tb_gpio_key_input.sv
// tb/tb_gpio_key_input.sv - self-checking bench for gpio_key_input against a window-based behavioural model
module tb_gpio_key_input;
  import gpio_key_pkg::*;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  pin_in = '1;
  logic [3:0]    bus_addr = '0;
  logic          bus_write = 1'b0;
  logic [31:0]   bus_wdata = '0;
  logic          bus_read = 1'b0;
  logic [31:0]   bus_rdata;
  logic [W-1:0]  level;
  logic          irq;

  always #5 clk = ~clk;

  gpio_key_input #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .pin_in(pin_in), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_read(bus_read), .bus_rdata(bus_rdata), .level(level), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  // Model: a key level flips once the last DEB synchronized samples all disagree with it.
  logic [W-1:0] m_dly [SYNC];
  logic [W-1:0] m_hist [$];
  logic [W-1:0] m_level, m_level_d, m_rise, m_fall, m_pending, m_irq_en, m_esel;
  logic [31:0]  m_rdata;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < SYNC; j++) m_dly[j] = '1;
    m_hist.delete();
    m_level = '0; m_level_d = '0; m_rise = '0; m_fall = '0;
    m_pending = '0; m_irq_en = '0; m_esel = '0; m_rdata = '0;
  endtask

  task automatic model_update();
    logic [W-1:0] s, nl, setm, clrm;
    logic [3:0]   off;
    off = {bus_addr[3:2], 2'b00};
    s = ~m_dly[SYNC-1];
    for (int j = SYNC - 1; j > 0; j--) m_dly[j] = m_dly[j-1];
    m_dly[0] = pin_in;
    m_hist.push_back(s);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    nl = m_level;
    for (int i = 0; i < W; i++) begin
      int run = 0;
      foreach (m_hist[k]) if (m_hist[k][i] != m_level[i]) run++;
      if (run == DEB) nl[i] = ~m_level[i];
    end
    setm = (m_rise & ~m_esel) | (m_fall & m_esel);
    clrm = (bus_write && off == GPIO_KEY_PENDING) ? bus_wdata[W-1:0] : '0;
    if (bus_read) begin
      m_rdata = '0;
      if (off == GPIO_KEY_DATA)     m_rdata[W-1:0] = m_level;
      if (off == GPIO_KEY_IRQ_EN)   m_rdata[W-1:0] = m_irq_en;
      if (off == GPIO_KEY_PENDING)  m_rdata[W-1:0] = m_pending;
      if (off == GPIO_KEY_EDGE_SEL) m_rdata[W-1:0] = m_esel;
    end
    if (bus_write && off == GPIO_KEY_IRQ_EN)   m_irq_en = bus_wdata[W-1:0];
    if (bus_write && off == GPIO_KEY_EDGE_SEL) m_esel = bus_wdata[W-1:0];
    m_pending = (m_pending & ~clrm) | setm;
    m_rise = m_level & ~m_level_d;
    m_fall = ~m_level & m_level_d;
    m_level_d = m_level;
    m_level = nl;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
    @(negedge clk);
    check("model_level", level, m_level);
    check("model_irq", irq, |(m_pending & m_irq_en));
    check("model_rdata", bus_rdata, m_rdata);
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_write = 1'b1;
    step();
    bus_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    bus_addr = a; bus_read = 1'b1;
    step();
    d = bus_rdata;
    bus_read = 1'b0;
  endtask

  task automatic wait_level(input int idx, input logic val, input string name, input int exp_n);
    int n = 0;
    while (level[idx] !== val && n < 50) begin
      step();
      n++;
    end
    check(name, n, exp_n);
  endtask

  initial begin
    logic [31:0] d;
    int hold [W];
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();
    check("reset_level", level, 0);
    check("reset_irq", irq, 0);
    bus_rd(GPIO_KEY_DATA, d);    check("reset_data", d, 0);
    bus_rd(GPIO_KEY_PENDING, d); check("reset_pending", d, 0);

    tbl[0]  = '{1'b1, 1'b0, GPIO_KEY_IRQ_EN,   32'hFFFF_FFFF, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, GPIO_KEY_IRQ_EN,   32'h0,         32'hF};
    tbl[2]  = '{1'b1, 1'b0, GPIO_KEY_EDGE_SEL, 32'hA5A5_A5A5, 32'hF};
    tbl[3]  = '{1'b0, 1'b1, GPIO_KEY_EDGE_SEL, 32'h0,         32'h5};
    tbl[4]  = '{1'b1, 1'b0, GPIO_KEY_DATA,     32'hF,         32'h5};
    tbl[5]  = '{1'b0, 1'b1, GPIO_KEY_DATA,     32'h0,         32'h0};
    tbl[6]  = '{1'b0, 1'b1, GPIO_KEY_PENDING,  32'h0,         32'h0};
    tbl[7]  = '{1'b1, 1'b1, GPIO_KEY_IRQ_EN,   32'h3,         32'hF};
    tbl[8]  = '{1'b0, 1'b1, GPIO_KEY_IRQ_EN,   32'h0,         32'h3};
    tbl[9]  = '{1'b0, 1'b0, GPIO_KEY_IRQ_EN,   32'h0,         32'h3};
    tbl[10] = '{1'b1, 1'b0, GPIO_KEY_EDGE_SEL, 32'h0,         32'h3};
    tbl[11] = '{1'b0, 1'b1, GPIO_KEY_EDGE_SEL, 32'h0,         32'h0};
    tbl[12] = '{1'b1, 1'b0, GPIO_KEY_IRQ_EN,   32'h0,         32'h0};
    for (int i = 0; i < 13; i++) begin
      bus_addr = tbl[i].addr; bus_wdata = tbl[i].wdata;
      bus_write = tbl[i].wr; bus_read = tbl[i].rd;
      step();
      check($sformatf("vec%0d_rdata", i), bus_rdata, tbl[i].exp);
      bus_write = 1'b0; bus_read = 1'b0;
    end

    // clean press of key 0, read collision with the pending set, W1C
    bus_wr(GPIO_KEY_IRQ_EN, 32'h1);
    pin_in = 4'hE;
    wait_level(0, 1'b1, "press0_latency", 6);
    step();
    bus_rd(GPIO_KEY_PENDING, d); check("pend_read_same_cycle", d, 0);
    check("irq_after_set", irq, 1);
    bus_rd(GPIO_KEY_PENDING, d); check("pend_visible", d, 1);
    bus_wr(GPIO_KEY_PENDING, 32'h1);
    check("irq_after_w1c", irq, 0);
    pin_in = 4'hF;
    wait_level(0, 1'b0, "release0_latency", 6);
    repeat (3) step();
    bus_rd(GPIO_KEY_PENDING, d); check("no_pend_on_fall", d, 0);

    // bouncing key 1
    for (int k = 0; k < 20; k++) begin
      pin_in[1] = ((k / 2) % 2) != 0;
      step();
    end
    pin_in[1] = 1'b0;
    wait_level(1, 1'b1, "bounce_latency", 6);
    repeat (3) step();
    bus_rd(GPIO_KEY_PENDING, d); check("bounce_one_pend", d, 32'h2);
    bus_wr(GPIO_KEY_PENDING, 32'h2);
    pin_in = 4'hF;
    wait_level(1, 1'b0, "bounce_release", 6);

    // falling-edge mode on key 2
    bus_wr(GPIO_KEY_EDGE_SEL, 32'h4);
    bus_wr(GPIO_KEY_IRQ_EN, 32'h4);
    pin_in = 4'hB;
    wait_level(2, 1'b1, "press2_latency", 6);
    repeat (4) step();
    bus_rd(GPIO_KEY_PENDING, d); check("no_pend_on_rise", d, 0);
    check("irq_none_on_rise", irq, 0);
    pin_in = 4'hF;
    wait_level(2, 1'b0, "release2_latency", 6);
    repeat (3) step();
    bus_rd(GPIO_KEY_PENDING, d); check("pend_on_fall", d, 32'h4);
    check("irq_on_fall", irq, 1);
    bus_wr(GPIO_KEY_PENDING, 32'h4);
    check("irq_drop_w1c", irq, 0);
    bus_wr(GPIO_KEY_EDGE_SEL, 32'h0);

    // W1C landing on the same edge as a set
    bus_wr(GPIO_KEY_IRQ_EN, 32'h1);
    pin_in = 4'hE;
    wait_level(0, 1'b1, "press0_again", 6);
    step();
    bus_wr(GPIO_KEY_PENDING, 32'h1);
    bus_rd(GPIO_KEY_PENDING, d); check("w1c_collision", d, 32'h1);
    check("irq_collision", irq, 1);
    bus_wr(GPIO_KEY_PENDING, 32'h1);

    // reset while key 3 is mid-count and key 0 is held
    pin_in = 4'h6;
    repeat (4) step();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_level_now", level, 0);
    check("rst_irq_now", irq, 0);
    repeat (2) step();
    rst = 1'b0;
    wait_level(3, 1'b1, "post_reset_latency", 6);
    check("post_reset_level", level, 32'h9);
    repeat (3) step();
    bus_rd(GPIO_KEY_PENDING, d); check("post_reset_pend", d, 32'h9);
    pin_in = 4'hF;
    repeat (12) step();

    // randomized pins and bus traffic against the model
    for (int i = 0; i < W; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < W; i++) begin
        if (hold[i] == 0) begin
          pin_in[i] = ~pin_in[i];
          hold[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(1, 4));
        end else begin
          hold[i]--;
        end
      end
      bus_addr  = 4'($urandom);
      bus_read  = 1'($urandom_range(0, 1));
      bus_write = ($urandom_range(0, 3) == 0);
      bus_wdata = $urandom;
      step();
    end
    bus_read = 1'b0;
    bus_write = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
